alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Moore FSM that sequences operand fetch (immediate or data memory), ALU execute and result report.
// Latency 4 cycles (two immediates) + 1 per memory operand; illegal opcode reports in 1 cycle.
module alu_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_alu_datapath,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_opcode,
    input  logic              req_src_a,
    input  logic              req_src_b,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [7:0]        req_imm_a,
    input  logic [7:0]        req_imm_b,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_rd,
    output logic [7:0]        imm_out,
    output logic [1:0]        cu_A,
    output logic [1:0]        cu_B,
    output logic [3:0]        opcode,
    output logic              RER,
    output logic              done,
    output logic              err_illegal,
    output logic              busy,
    output logic [7:0]        op_count
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    typedef enum logic [2:0] {
        IDLE, LOAD_A, WAIT_A, LOAD_B, WAIT_B, EXEC, DONE
    } state_t;

    state_t              state_q;
    logic [3:0]          opc_q;
    logic                src_a_q, src_b_q;
    logic [ADDR_W-1:0]   addr_a_q, addr_b_q;
    logic [7:0]          imm_a_q, imm_b_q;
    logic                err_q;
    logic [7:0]          cnt_q;
    logic                legal;

    always_comb begin
        legal = 1'b0;
        case (req_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset_alu_datapath) begin
        if (reset_alu_datapath) begin
            state_q  <= IDLE;
            opc_q    <= '0;
            src_a_q  <= 1'b0;
            src_b_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            imm_a_q  <= '0;
            imm_b_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        opc_q    <= req_opcode;
                        src_a_q  <= req_src_a;
                        src_b_q  <= req_src_b;
                        addr_a_q <= req_addr_a;
                        addr_b_q <= req_addr_b;
                        imm_a_q  <= req_imm_a;
                        imm_b_q  <= req_imm_b;
                        err_q    <= ~legal;
                        state_q  <= legal ? LOAD_A : DONE;
                    end
                end
                LOAD_A:  state_q <= src_a_q ? LOAD_B : WAIT_A;
                WAIT_A:  state_q <= LOAD_B;
                LOAD_B:  state_q <= src_b_q ? EXEC : WAIT_B;
                WAIT_B:  state_q <= EXEC;
                EXEC:    state_q <= DONE;
                DONE: begin
                    cnt_q   <= cnt_q + 8'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode purely from state and captured fields, so reset forces them to idle values.
    always_comb begin
        dmem_addr   = '0;
        dmem_rd     = 1'b0;
        imm_out     = 8'h00;
        cu_A        = 2'b00;
        cu_B        = 2'b00;
        RER         = 1'b0;
        done        = 1'b0;
        err_illegal = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (src_a_q) begin
                    cu_A    = 2'b11;
                    imm_out = imm_a_q;
                end else begin
                    dmem_addr = addr_a_q;
                    dmem_rd   = 1'b1;
                end
            end
            WAIT_A: cu_A = 2'b10;
            LOAD_B: begin
                if (src_b_q) begin
                    cu_B    = 2'b11;
                    imm_out = imm_b_q;
                end else begin
                    dmem_addr = addr_b_q;
                    dmem_rd   = 1'b1;
                end
            end
            WAIT_B: cu_B = 2'b10;
            EXEC:   RER  = 1'b1;
            DONE: begin
                done        = 1'b1;
                err_illegal = err_q;
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign opcode    = opc_q;
    assign op_count  = cnt_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small data-memory and operand/result datapath model.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       reset_alu_datapath;
    logic       req_valid, req_ready;
    logic [3:0] req_opcode;
    logic       req_src_a, req_src_b;
    logic [7:0] req_addr_a, req_addr_b, req_imm_a, req_imm_b;
    logic [7:0] dmem_addr, imm_out, op_count;
    logic       dmem_rd, RER, done, err_illegal, busy;
    logic [1:0] cu_A, cu_B;
    logic [3:0] opcode;

    alu_sequencer #(.ADDR_W(8)) dut (
        .clk(clk), .reset_alu_datapath(reset_alu_datapath),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_src_a(req_src_a), .req_src_b(req_src_b),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
        .req_imm_a(req_imm_a), .req_imm_b(req_imm_b),
        .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .imm_out(imm_out),
        .cu_A(cu_A), .cu_B(cu_B), .opcode(opcode), .RER(RER), .done(done),
        .err_illegal(err_illegal), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Datapath model: registered memory read, operand registers, result register.
    logic [7:0] mem [0:255];
    logic [7:0] dmem_data = 8'h00;
    logic [7:0] a_m = 8'h00, b_m = 8'h00, r_m = 8'h00;
    int         rer_total = 0, hs_total = 0, done_total = 0;

    always @(posedge clk) begin
        if (dmem_rd) dmem_data <= mem[dmem_addr];
        if (cu_A == 2'b10) a_m <= dmem_data;
        else if (cu_A == 2'b11) a_m <= imm_out;
        if (cu_B == 2'b10) b_m <= dmem_data;
        else if (cu_B == 2'b11) b_m <= imm_out;
        if (RER) begin
            case (opcode)
                4'd0: r_m <= a_m + b_m;
                4'd1: r_m <= a_m - b_m;
                4'd2: r_m <= a_m & b_m;
                4'd3: r_m <= a_m | b_m;
                4'd4: r_m <= a_m ^ b_m;
                default: r_m <= r_m;
            endcase
        end
        if (RER) rer_total <= rer_total + 1;
        if (done) done_total <= done_total + 1;
        if (req_valid && req_ready) hs_total <= hs_total + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 1);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " err_illegal"}, 32'(err_illegal), 0);
        check({tag, " RER"}, 32'(RER), 0);
        check({tag, " dmem_rd"}, 32'(dmem_rd), 0);
        check({tag, " cu_AB"}, 32'({cu_A, cu_B}), 0);
        check({tag, " opcode"}, 32'(opcode), 0);
        check({tag, " imm_out"}, 32'(imm_out), 0);
        check({tag, " dmem_addr"}, 32'(dmem_addr), 0);
    endtask

    logic [1:0] log_cuA [0:15];
    logic [1:0] log_cuB [0:15];
    logic       log_rd  [0:15];
    logic [7:0] log_addr[0:15];
    logic [7:0] log_imm [0:15];
    int         lat, rer_diff, hs_start;
    logic [7:0] r_done;
    logic       err_done;
    logic [7:0] exp_cnt = 8'd0;

    // Handshake one op and follow it to its done cycle (bounded); leaves time in the done cycle.
    task automatic run_op(input logic [3:0] opc, input logic sa, input logic sb,
                          input logic [7:0] aa, input logic [7:0] ab,
                          input logic [7:0] ia, input logic [7:0] ib, input bit hold);
        int n, rer0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        req_opcode = opc; req_src_a = sa; req_src_b = sb;
        req_addr_a = aa; req_addr_b = ab; req_imm_a = ia; req_imm_b = ib;
        req_valid = 1'b1;
        rer0 = rer_total;
        hs_start = hs_total;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            log_cuA[i] = 2'b00; log_cuB[i] = 2'b00; log_rd[i] = 1'b0;
            log_addr[i] = 8'h00; log_imm[i] = 8'h00;
        end
        lat = 1;
        forever begin
            log_cuA[lat] = cu_A; log_cuB[lat] = cu_B; log_rd[lat] = dmem_rd;
            log_addr[lat] = dmem_addr; log_imm[lat] = imm_out;
            if (done || lat >= 12) break;
            @(posedge clk); #1;
            lat++;
        end
        r_done   = r_m;
        err_done = err_illegal;
        rer_diff = rer_total - rer0;
        exp_cnt  = exp_cnt + 8'd1;
    endtask

    task automatic after_op(input string tag);
        @(posedge clk); #1;
        check({tag, " op_count"}, 32'(op_count), 32'(exp_cnt));
    endtask

    logic [7:0] r_prev;
    int         d0, rr0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h10] = 8'h20;
        mem[8'h00] = 8'hF0;
        mem[8'h01] = 8'hFF;
        reset_alu_datapath = 1'b1;
        req_valid = 1'b0; req_opcode = 4'd0; req_src_a = 1'b0; req_src_b = 1'b0;
        req_addr_a = 8'h00; req_addr_b = 8'h00; req_imm_a = 8'h00; req_imm_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_idle("in_reset");
        #3 reset_alu_datapath = 1'b0;
        @(posedge clk); #1;
        check_idle("post_reset");
        check("post_reset op_count", 32'(op_count), 0);

        // ADD 5 + 3, both immediates
        run_op(4'd0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h05, 8'h03, 1'b0);
        check("add cuA", 32'(log_cuA[1]), 32'h3);
        check("add immA", 32'(log_imm[1]), 32'h05);
        check("add cuB", 32'(log_cuB[2]), 32'h3);
        check("add immB", 32'(log_imm[2]), 32'h03);
        check("add latency", 32'(lat), 4);
        check("add R", 32'(r_done), 32'h08);
        check("add err", 32'(err_done), 0);
        check("add RER pulses", 32'(rer_diff), 1);
        after_op("add");
        check("add op_count value", 32'(op_count), 1);

        // SUB mem[0x10]=0x20 minus 1
        run_op(4'd1, 1'b0, 1'b1, 8'h10, 8'h00, 8'h00, 8'h01, 1'b0);
        check("sub dmem_rd", 32'(log_rd[1]), 1);
        check("sub dmem_addr", 32'(log_addr[1]), 32'h10);
        check("sub cuA wait", 32'(log_cuA[2]), 32'h2);
        check("sub latency", 32'(lat), 5);
        check("sub R", 32'(r_done), 32'h1F);
        check("sub RER pulses", 32'(rer_diff), 1);
        after_op("sub");

        // XOR both memory operands, req_valid held high throughout
        run_op(4'd4, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1);
        check("xor rd B addr", 32'({log_rd[3], log_addr[3]}), 32'h101);
        check("xor cuB wait", 32'(log_cuB[4]), 32'h2);
        check("xor latency", 32'(lat), 6);
        check("xor R", 32'(r_done), 32'h0F);
        check("xor no accept while busy", 32'(hs_total - hs_start), 1);
        after_op("xor");
        check("xor ready after done", 32'(req_ready), 1);
        run_op(4'd3, 1'b1, 1'b1, 8'h00, 8'h00, 8'h0C, 8'h30, 1'b0);
        check("or b2b latency", 32'(lat), 4);
        check("or b2b R", 32'(r_done), 32'h3C);
        after_op("or");

        // Illegal opcode
        r_prev = r_m;
        run_op(4'hF, 1'b1, 1'b1, 8'h00, 8'h00, 8'hAA, 8'h55, 1'b0);
        check("ill latency", 32'(lat), 1);
        check("ill err", 32'(err_done), 1);
        check("ill RER pulses", 32'(rer_diff), 0);
        check("ill R unchanged", 32'(r_done), 32'(r_prev));
        after_op("ill");
        check("ill err cleared", 32'(err_illegal), 0);

        // Reset during WAIT_B
        req_opcode = 4'd4; req_src_a = 1'b0; req_src_b = 1'b0;
        req_addr_a = 8'h00; req_addr_b = 8'h01; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst wait_b cuB", 32'(cu_B), 32'h2);
        d0 = done_total; rr0 = rer_total;
        reset_alu_datapath = 1'b1;
        #1;
        check_idle("rst immediate");
        check("rst op_count", 32'(op_count), 0);
        @(posedge clk); #1;
        reset_alu_datapath = 1'b0;
        @(posedge clk); #1;
        check_idle("rst first cycle");
        repeat (6) begin @(posedge clk); #1; end
        check("rst no done", 32'(done_total - d0), 0);
        check("rst no RER", 32'(rer_total - rr0), 0);
        exp_cnt = 8'd0;

        // op_count wrap after 256 completions
        for (int k = 0; k < 255; k++) begin
            run_op(4'hE, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
            @(posedge clk); #1;
        end
        check("wrap 255", 32'(op_count), 32'd255);
        run_op(4'hE, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("wrap to 0", 32'(op_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
